// File: rtl/keycode_evt_pkg.sv
// Shared encodings for the keycode event controller: event types, FSM states,
// the packed event word carried through the queue, and small helpers.
package keycode_evt_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam int         EVT_W    = 10;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_SWAP
    } state_e;

    typedef struct packed {
        evt_type_e  typ;
        logic [7:0] code;
    } evt_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event queue; DEPTH must be a power of two (>= 2).
// A push into a full queue is accepted only when a pop happens in the same cycle.
module evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign valid_o   = (count_q != '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign pop_en  = pop_i && valid_o;
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_en && !pop_en)      count_d = count_q + (AW+1)'(1);
        else if (pop_en && !push_en) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/keycode_event_ctrl.sv
// Turns a level keycode into PRESS / RELEASE / auto-REPEAT events and queues
// them for a consumer; a dropped push sets a sticky overflow flag.
module keycode_event_ctrl
    import keycode_evt_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [7:0]                  keycode,
    input  logic                        evt_ready,
    input  logic                        clr_overflow,
    output logic                        evt_valid,
    output logic [7:0]                  evt_code,
    output logic [1:0]                  evt_type,
    output logic [7:0]                  held_code,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int CNT_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    state_e            state_q, state_d;
    logic [7:0]        kc_q;
    logic [7:0]        held_q, held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              push;
    evt_t              push_evt;
    logic              fifo_full, pop, drop;
    logic [EVT_W-1:0]  head;
    logic              timer_done;

    assign timer_done = (state_q == ST_DELAY) ? (cnt_q == DELAY_LAST) : (cnt_q == RATE_LAST);

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        push_evt = '{typ: EVT_PRESS, code: KEY_NONE};
        case (state_q)
            ST_IDLE: begin
                if (kc_q != KEY_NONE) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_PRESS, code: kc_q};
                    held_d   = kc_q;
                    cnt_d    = '0;
                    state_d  = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // A key change takes priority over a timer expiring in the same cycle.
                if (kc_q == KEY_NONE) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_RELEASE, code: held_q};
                    held_d   = KEY_NONE;
                    state_d  = ST_IDLE;
                end else if (kc_q != held_q) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_RELEASE, code: held_q};
                    state_d  = ST_SWAP;
                end else if (timer_done) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_REPEAT, code: held_q};
                    cnt_d    = '0;
                    state_d  = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SWAP: begin
                if (kc_q != KEY_NONE) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_PRESS, code: kc_q};
                    held_d   = kc_q;
                    cnt_d    = '0;
                    state_d  = ST_DELAY;
                end else begin
                    held_d  = KEY_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop  = evt_valid && evt_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (clr_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            kc_q    <= KEY_NONE;
            held_q  <= KEY_NONE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kc_q    <= keycode;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .push_i    (push),
        .wr_data_i (push_evt),
        .pop_i     (pop),
        .rd_data_o (head),
        .valid_o   (evt_valid),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign evt_code  = head[7:0];
    assign evt_type  = head[9:8];
    assign held_code = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Directed plus randomized bench for keycode_event_ctrl, scored against a
// timestamp-based event model and a bounded queue.
module tb_keycode_event_ctrl;

    localparam int RD = 20;
    localparam int RR = 5;
    localparam int FD = 8;
    localparam logic [1:0] T_PRESS = 2'b01;
    localparam logic [1:0] T_REL   = 2'b10;
    localparam logic [1:0] T_REP   = 2'b11;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [1:0] evt_type;
    logic [7:0] held_code;
    logic [3:0] fifo_count;
    logic       overflow;

    keycode_event_ctrl #(
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .FIFO_DEPTH   (FD)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .held_code    (held_code),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct packed { logic [1:0] t; logic [7:0] c; } ev_t;
    typedef struct { int n; logic [1:0] t; logic [7:0] c; } log_t;

    // Model: registered key, held key, pending-press flag after a key swap,
    // and the absolute edge number at which the next REPEAT is due.
    ev_t        mq[$];
    logic [7:0] m_kc, m_held;
    bit         m_swap, m_ovf;
    int         m_next;
    log_t       lg[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_kc = 8'h00; m_held = 8'h00; m_swap = 0; m_ovf = 0; m_next = 0;
    endtask

    task automatic model_edge(input logic [7:0] kc, input bit rdy, input bit clr);
        bit  pushed, pop, drop;
        ev_t e;
        pushed = 0; drop = 0; e = '0;
        pop = rdy && (mq.size() > 0);
        if (m_swap) begin
            m_swap = 0;
            if (m_kc != 0) begin pushed = 1; e = '{T_PRESS, m_kc}; m_held = m_kc; m_next = cyc_n + RD; end
            else m_held = 0;
        end else if (m_held == 0) begin
            if (m_kc != 0) begin pushed = 1; e = '{T_PRESS, m_kc}; m_held = m_kc; m_next = cyc_n + RD; end
        end else if (m_kc == 0) begin
            pushed = 1; e = '{T_REL, m_held}; m_held = 0;
        end else if (m_kc != m_held) begin
            pushed = 1; e = '{T_REL, m_held}; m_swap = 1;
        end else if (cyc_n == m_next) begin
            pushed = 1; e = '{T_REP, m_held}; m_next = cyc_n + RR;
        end
        if (pop) void'(mq.pop_front());
        if (pushed) begin
            if (mq.size() >= FD) drop = 1;
            else mq.push_back(e);
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_kc = kc;
    endtask

    task automatic compare_all();
        chk("evt_valid", evt_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
            chk("evt_code", evt_code, mq[0].c);
            chk("evt_type", evt_type, mq[0].t);
        end
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("held_code", held_code, m_held);
    endtask

    task automatic cyc(input logic [7:0] kc, input bit rdy, input bit clr);
        keycode = kc; evt_ready = rdy; clr_overflow = clr;
        model_edge(kc, rdy, clr);
        @(posedge Clk); #1;
        cyc_n++;
        compare_all();
        if (evt_valid) lg.push_back('{n: cyc_n, t: evt_type, c: evt_code});
    endtask

    initial begin
        model_reset();
        #1 Reset = 1'b1;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_held", held_code, 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        repeat (3) cyc(8'h00, 1, 0);

        // First press: two-edge latency, popped next cycle.
        cyc(8'h04, 1, 0);
        chk("lat_edge1_valid", evt_valid, 0);
        cyc(8'h04, 1, 0);
        chk("lat_edge2_valid", evt_valid, 1);
        chk("lat_type", evt_type, T_PRESS);
        chk("lat_code", evt_code, 8'h04);
        cyc(8'h04, 1, 0);
        chk("popped_valid", evt_valid, 0);
        chk("held_04", held_code, 8'h04);
        repeat (4) cyc(8'h00, 1, 0);

        // Hold 40 clocks: PRESS, REPEATs at +20/+25/+30/+35, RELEASE at +40.
        lg.delete();
        repeat (40) cyc(8'h04, 1, 0);
        repeat (4) cyc(8'h00, 1, 0);
        chk("hold_nevents", lg.size(), 6);
        if (lg.size() >= 6) begin
            chk("hold_t0", lg[0].t, T_PRESS);
            chk("hold_t1", lg[1].t, T_REP);
            chk("hold_d1", lg[1].n - lg[0].n, 20);
            chk("hold_d2", lg[2].n - lg[0].n, 25);
            chk("hold_d3", lg[3].n - lg[0].n, 30);
            chk("hold_d4", lg[4].n - lg[0].n, 35);
            chk("hold_t5", lg[5].t, T_REL);
            chk("hold_c5", lg[5].c, 8'h04);
            chk("hold_d5", lg[5].n - lg[0].n, 40);
        end
        chk("hold_held0", held_code, 0);

        // Direct swap 0x04 -> 0x16.
        lg.delete();
        repeat (10) cyc(8'h04, 1, 0);
        repeat (30) cyc(8'h16, 1, 0);
        repeat (4) cyc(8'h00, 1, 0);
        chk("swap_nevents", lg.size(), 6);
        if (lg.size() >= 4) begin
            chk("swap_rel_t", lg[1].t, T_REL);
            chk("swap_rel_c", lg[1].c, 8'h04);
            chk("swap_prs_t", lg[2].t, T_PRESS);
            chk("swap_prs_c", lg[2].c, 8'h16);
            chk("swap_consec", lg[2].n - lg[1].n, 1);
            chk("swap_rep_c", lg[3].c, 8'h16);
            chk("swap_rep_d", lg[3].n - lg[2].n, 20);
        end

        // Overflow: 10 events into an 8-deep queue with no consumer.
        for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? 8'h04 : 8'h00, 0, 0);
        repeat (4) cyc(8'h00, 0, 0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_t", evt_type, T_PRESS);
        cyc(8'h00, 0, 1);
        chk("ovf_cleared", overflow, 0);

        // Full queue: push and pop in the same cycle.
        cyc(8'h04, 0, 0);
        lg.delete();
        cyc(8'h04, 1, 0);
        chk("full_pp_count", fifo_count, 8);
        chk("full_pp_ovf", overflow, 0);
        repeat (8) cyc(8'h04, 1, 0);
        chk("drain_n", lg.size(), 8);
        if (lg.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("drain_t", lg[i].t, (i % 2 == 0) ? T_REL : T_PRESS);
                chk("drain_c", lg[i].c, 8'h04);
            end
        end
        repeat (4) cyc(8'h00, 1, 0);

        // Reset mid-hold with three queued events.
        repeat (30) cyc(8'h04, 0, 0);
        chk("pre_rst_count", fifo_count, 3);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_held", held_code, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        lg.delete();
        repeat (10) cyc(8'h04, 1, 0);
        chk("postrst_n", lg.size(), 1);
        if (lg.size() >= 1) begin
            chk("postrst_t", lg[0].t, T_PRESS);
            chk("postrst_c", lg[0].c, 8'h04);
        end
        repeat (4) cyc(8'h00, 1, 0);

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 120; s++) begin
            logic [7:0] k;
            int         len, rp;
            case ($urandom_range(0, 3))
                0:       k = 8'h00;
                1:       k = 8'h04;
                2:       k = 8'h16;
                default: k = 8'h2A;
            endcase
            len = $urandom_range(1, 30);
            rp  = $urandom_range(0, 4);
            for (int i = 0; i < len; i++)
                cyc(k, ($urandom_range(0, 3) < rp), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keycode_event_ctrl.md
KEYCODE_EVENT_CTRL -- requirements
Module: keycode_event_ctrl

Interface
REQ-001 Parameter: REPEAT_DELAY, default 25_000_000, clocks a key is held before the first REPEAT (0.5 s at 50 MHz).
REQ-002 Parameter: REPEAT_RATE, default 5_000_000, clocks between successive REPEATs.
REQ-003 Parameter: FIFO_DEPTH, default 8, event queue depth (power of 2).
REQ-004 Clk  in  1  the single system clock; all logic is clocked on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 keycode  in  8  USB keycode from the SoC keycode PIO; 0x00 = no key.
REQ-007 evt_ready  in  1  consumer accepts the head event this cycle.
REQ-008 clr_overflow  in  1  one-cycle pulse; clears overflow.
REQ-009 evt_valid  out  1  FIFO non-empty; head event is presented.
REQ-010 evt_code  out  8  keycode of the head event.
REQ-011 evt_type  out  2  01 PRESS, 10 RELEASE, 11 REPEAT; 00 is never emitted.
REQ-012 held_code  out  8  keycode currently tracked as held; 0x00 in IDLE.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued events.
REQ-014 overflow  out  1  sticky; set when a push is dropped.

Function
REQ-015 keycode SHALL be registered once (kc_q); the FSM SHALL act only on kc_q.
REQ-016 FSM states SHALL be IDLE, DELAY, REPEAT, SWAP.
REQ-017 IDLE, kc_q!=0: push PRESS(kc_q), held_code<=kc_q, counter<=0, go to DELAY.
REQ-018 DELAY/REPEAT, kc_q==0: push RELEASE(held_code), held_code<=0, go to IDLE.
REQ-019 DELAY/REPEAT, kc_q!=0 and kc_q!=held_code: push RELEASE(held_code), go to SWAP.
REQ-020 SWAP: push PRESS(kc_q), held_code<=kc_q, counter<=0, go to DELAY; if kc_q==0 in SWAP, push nothing, held_code<=0, go to IDLE.
REQ-021 DELAY, counter==REPEAT_DELAY-1: push REPEAT(held_code), counter<=0, go to REPEAT; otherwise counter increments.
REQ-022 REPEAT, counter==REPEAT_RATE-1: push REPEAT(held_code), counter<=0; otherwise counter increments.
REQ-023 Key change and timer expiry in the same cycle: the key-change transition wins; no REPEAT is pushed.
REQ-024 At most one push per cycle.
REQ-025 Latency: a keycode change at the input edge N SHALL produce evt_valid at edge N+2 when the FIFO was empty.
REQ-026 FIFO SHALL be first-word-fall-through; pop occurs when evt_valid && evt_ready.
REQ-027 Push while full and no pop: event dropped, overflow<=1, FIFO contents and FSM transition unaffected.
REQ-028 Push and pop in the same cycle while full: both occur, fifo_count stays FIFO_DEPTH, overflow unchanged.
REQ-029 Push and pop in the same cycle while empty is impossible (evt_valid=0); the push is visible the next cycle.
REQ-030 evt_ready while empty SHALL be ignored.
REQ-031 clr_overflow coincident with a dropped push SHALL leave overflow=1 (set wins).
REQ-032 Counters SHALL be wide enough for max(REPEAT_DELAY, REPEAT_RATE) and SHALL never wrap past the terminal value.

Reset
REQ-033 Reset SHALL asynchronously force: state IDLE; kc_q, held_code, counter, fifo_count, overflow, evt_valid all 0; FIFO pointers 0.
REQ-034 Reset mid-hold SHALL discard all queued events and emit no RELEASE; a key still held after release of Reset SHALL produce a fresh PRESS.

Structure
REQ-035 Package keycode_evt_pkg SHALL hold the evt_type encoding (EVT_PRESS, EVT_RELEASE, EVT_REPEAT), the FSM state enum, and KEY_NONE=8'h00.
REQ-036 The queue SHALL be a separate sub-module, evt_fifo (parameterised width 10, depth FIFO_DEPTH); the FSM and timers stay in keycode_event_ctrl.

Verification (bench uses REPEAT_DELAY=20, REPEAT_RATE=5, FIFO_DEPTH=8)
REQ-037 keycode 0x00->0x04, evt_ready=1 -> evt_valid two edges later, PRESS/0x04, popped the next cycle; held_code=0x04.
REQ-038 Hold 0x04 for 40 clocks then 0x00 -> PRESS, REPEAT at +20, REPEAT at +25, +30, +35, then RELEASE/0x04; held_code=0.
REQ-039 0x04 held, switch directly to 0x16 -> RELEASE/0x04 then PRESS/0x16 on consecutive pushes; DELAY timer restarts.
REQ-040 evt_ready=0, toggle the key 0x04/0x00 to generate 10 events -> fifo_count=8, overflow=1, first 8 events intact in order; clr_overflow -> overflow=0.
REQ-041 FIFO full, evt_ready=1 while a new event is pushed -> fifo_count stays 8, overflow stays 0.
REQ-042 Assert Reset while 0x04 is held with 3 events queued -> evt_valid=0, fifo_count=0; after deassert, a single PRESS/0x04 and no RELEASE.
